game_state_nxn: RTL

Parametrised successor to the tic-tac-toe game-state engine. It holds an N×N board for players X and O and accepts one move at a time through a valid/ready handshake. It enforces turn order and rejects illegal moves with a typed error code. After each placement it runs a fixed-latency sequential win/draw check that examines only the lines passing through the placed cell. It sits between the move-input logic (buttons/AI) and the display/scoring logic.

---
 rtl/game_pkg.sv | 32 +++
 rtl/gs_line_extract.sv | 40 ++++
 rtl/game_state_nxn.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants and types for the N x N game-state engine.
package game_pkg;

  localparam logic [1:0] ST_PLAY = 2'b00;
  localparam logic [1:0] ST_XWIN = 2'b01;
  localparam logic [1:0] ST_OWIN = 2'b10;
  localparam logic [1:0] ST_DRAW = 2'b11;

  localparam logic [1:0] ERR_OVER  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_TURN  = 2'b10;
  localparam logic [1:0] ERR_OCC   = 2'b11;

  localparam logic PLAYER_X = 1'b1;
  localparam logic PLAYER_O = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_ROW,
    S_CHK_COL,
    S_CHK_DIAG,
    S_CHK_ANTI
  } state_e;

  typedef enum logic [1:0] {
    LN_ROW,
    LN_COL,
    LN_DIAG,
    LN_ANTI
  } line_e;

endpackage

// File: rtl/gs_line_extract.sv
// Combinational selector returning one row, column or diagonal of a board.
module gs_line_extract
  import game_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N*N-1:0] board_i,
  input  line_e          line_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [N-1:0]   line_o
);

  logic [N-1:0] rows [N];
  logic [N-1:0] cols [N];
  logic [N-1:0] diag;
  logic [N-1:0] anti;

  // Reshape the flat board so every line is a constant-index slice.
  for (genvar r = 0; r < N; r++) begin : g_r
    for (genvar c = 0; c < N; c++) begin : g_c
      assign rows[r][c] = board_i[r*N+c];
      assign cols[c][r] = board_i[r*N+c];
    end
    assign diag[r] = board_i[r*N+r];
    assign anti[r] = board_i[r*N+(N-1-r)];
  end

  always_comb begin
    line_o = '0;
    case (line_i)
      LN_ROW:  line_o = rows[idx_i];
      LN_COL:  line_o = cols[idx_i];
      LN_DIAG: line_o = diag;
      LN_ANTI: line_o = anti;
      default: line_o = '0;
    endcase
  end

endmodule

// File: rtl/game_state_nxn.sv
// N x N two-player game-state engine: move legality, board update and a
// four-cycle win/draw scan of the lines through the placed cell.
module game_state_nxn
  import game_pkg::*;
#(
  parameter int unsigned N            = 3,
  parameter bit          FIRST_PLAYER = 1'b1,
  parameter int unsigned IDX_W        = $clog2(N)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       move_i,
  output logic                       ready_o,
  input  logic                       player_i,
  input  logic [IDX_W-1:0]           row_i,
  input  logic [IDX_W-1:0]           col_i,
  output logic [N*N-1:0]             x_state_o,
  output logic [N*N-1:0]             o_state_o,
  output logic [1:0]                 game_status_o,
  output logic                       turn_o,
  output logic [$clog2(N*N+1)-1:0]   move_count_o,
  output logic                       move_done_o,
  output logic                       move_err_o,
  output logic [1:0]                 err_code_o
);

  localparam int unsigned CELLS = N * N;
  localparam int unsigned CNT_W = $clog2(N * N + 1);
  localparam int unsigned XW    = IDX_W + 1;

  state_e           state_q, state_d;
  logic [CELLS-1:0] x_q, x_d, o_q, o_d;
  logic [1:0]       status_q, status_d;
  logic             turn_q, turn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic             plr_q, plr_d, hit_q, hit_d;

  logic [CELLS-1:0] take_mask;
  logic             range_bad, occupied, on_diag, on_anti, line_full, final_hit;
  line_e            line_sel;
  logic [IDX_W-1:0] line_idx;
  logic [N-1:0]     line_bits;

  for (genvar r = 0; r < N; r++) begin : g_mr
    for (genvar c = 0; c < N; c++) begin : g_mc
      assign take_mask[r*N+c] = (row_i == IDX_W'(r)) && (col_i == IDX_W'(c));
    end
  end

  assign range_bad = ({1'b0, row_i} >= XW'(N)) || ({1'b0, col_i} >= XW'(N));
  assign occupied  = |(take_mask & (x_q | o_q));
  assign on_diag   = (row_q == col_q);
  assign on_anti   = (({1'b0, row_q} + {1'b0, col_q}) == XW'(N - 1));

  // Line selection follows the check state; the column check uses col_q.
  always_comb begin
    line_sel = LN_ROW;
    line_idx = row_q;
    case (state_q)
      S_CHK_COL:  begin line_sel = LN_COL; line_idx = col_q; end
      S_CHK_DIAG: line_sel = LN_DIAG;
      S_CHK_ANTI: line_sel = LN_ANTI;
      default:    line_sel = LN_ROW;
    endcase
  end

  gs_line_extract #(.N(N), .IDX_W(IDX_W)) u_line (
    .board_i (plr_q ? x_q : o_q),
    .line_i  (line_sel),
    .idx_i   (line_idx),
    .line_o  (line_bits)
  );

  assign line_full = &line_bits;
  assign final_hit = hit_q | (line_full & on_anti);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    o_d      = o_q;
    status_d = status_q;
    turn_d   = turn_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    row_d    = row_q;
    col_d    = col_q;
    plr_d    = plr_q;
    hit_d    = hit_q;
    case (state_q)
      S_IDLE: begin
        if (move_i) begin
          if (status_q != ST_PLAY) begin
            err_d = 1'b1; code_d = ERR_OVER;
          end else if (range_bad) begin
            err_d = 1'b1; code_d = ERR_RANGE;
          end else if (player_i != turn_q) begin
            err_d = 1'b1; code_d = ERR_TURN;
          end else if (occupied) begin
            err_d = 1'b1; code_d = ERR_OCC;
          end else begin
            if (player_i == PLAYER_X) x_d = x_q | take_mask;
            else                      o_d = o_q | take_mask;
            cnt_d   = cnt_q + CNT_W'(1);
            row_d   = row_i;
            col_d   = col_i;
            plr_d   = player_i;
            hit_d   = 1'b0;
            state_d = S_CHK_ROW;
          end
        end
      end
      S_CHK_ROW: begin
        hit_d   = hit_q | line_full;
        state_d = S_CHK_COL;
      end
      S_CHK_COL: begin
        hit_d   = hit_q | line_full;
        state_d = S_CHK_DIAG;
      end
      S_CHK_DIAG: begin
        hit_d   = hit_q | (line_full & on_diag);
        state_d = S_CHK_ANTI;
      end
      S_CHK_ANTI: begin
        // A win on the last free cell takes precedence over a draw.
        if (final_hit)                      status_d = plr_q ? ST_XWIN : ST_OWIN;
        else if (cnt_q == CNT_W'(CELLS))    status_d = ST_DRAW;
        hit_d   = final_hit;
        turn_d  = ~turn_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      o_q      <= '0;
      status_q <= ST_PLAY;
      turn_q   <= FIRST_PLAYER;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_OVER;
      row_q    <= '0;
      col_q    <= '0;
      plr_q    <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      o_q      <= o_d;
      status_q <= status_d;
      turn_q   <= turn_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
      row_q    <= row_d;
      col_q    <= col_d;
      plr_q    <= plr_d;
      hit_q    <= hit_d;
    end
  end

  assign ready_o       = (state_q == S_IDLE);
  assign x_state_o     = x_q;
  assign o_state_o     = o_q;
  assign game_status_o = status_q;
  assign turn_o        = turn_q;
  assign move_count_o  = cnt_q;
  assign move_done_o   = done_q;
  assign move_err_o    = err_q;
  assign err_code_o    = code_q;

endmodule
